// File: rtl/eth_tg_pkg.sv
// eth_tg_pkg: shared constants, state encodings and helpers for the Ethernet traffic generator/checker.
package eth_tg_pkg;
   localparam int HDR_LEN = 14;
   localparam int MIN_LEN = 46;
   typedef enum logic {MODE_INC = 1'b0, MODE_INV = 1'b1} mode_e;
   typedef enum logic [1:0] {G_IDLE, G_SEND, G_GAP, G_FIN} gen_state_e;
   typedef enum logic [1:0] {C_IDLE, C_RECV, C_DRAIN} chk_state_e;
   function automatic logic [15:0] last_lanes(input logic [15:0] total, input int nb);
      logic [15:0] r;
      r = total % 16'(nb);
      return (r == '0) ? 16'(nb) : r;
   endfunction
endpackage

// File: rtl/eth_tg_pattern.sv
// eth_tg_pattern: combinational byte-lane generator for one beat of a test frame.
module eth_tg_pattern import eth_tg_pkg::*; #(
   parameter int DW = 64
) (
   input  logic [7:0]      frame,
   input  logic [10:0]     beat,
   input  logic [10:0]     len,
   input  logic            mode,
   input  logic [47:0]     dst,
   input  logic [47:0]     src,
   output logic [DW-1:0]   data,
   output logic [DW/8-1:0] keep,
   output logic            last
);
   localparam int NB = DW / 8;
   logic [15:0] t, lanes;
   assign t = 16'(len) + 16'(HDR_LEN);
   assign last = (16'(beat) + 16'd1) * 16'(NB) >= t;
   assign lanes = last_lanes(t, NB);
   for (genvar i = 0; i < NB; i++) begin : g_lane
      logic [15:0] b;
      logic [2:0] m;
      logic [7:0] pk;
      assign b = 16'(beat) * 16'(NB) + 16'(i);
      // m selects the MAC byte, MSB first, for header bytes 0..11
      assign m = 3'd5 - ((b < 16'd6) ? b[2:0] : 3'(b - 16'd6));
      assign pk = b[7:0] - 8'(HDR_LEN);
      assign data[8*i +: 8] = (b < 16'd6)   ? 8'(dst >> {m, 3'b000}) :
                              (b < 16'd12)  ? 8'(src >> {m, 3'b000}) :
                              (b == 16'd12) ? {5'd0, len[10:8]} :
                              (b == 16'd13) ? len[7:0] :
                              (mode == MODE_INV) ? ~pk : pk + frame;
      assign keep[i] = !last || 16'(i) < lanes;
   end
endmodule

// File: rtl/eth_traffic_gen_chk.sv
// eth_traffic_gen_chk: Ethernet-II frame generator and independent loopback checker with good/bad frame counters.
module eth_traffic_gen_chk import eth_tg_pkg::*; #(
   parameter int DW = 64,
   parameter int MAX_LEN = 1500,
   parameter int CNT_W = 16,
   parameter int IFG_CYCLES = 12
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [CNT_W-1:0] cfg_frames_i,
   input  logic [10:0]      cfg_len_i,
   input  logic             cfg_mode_i,
   input  logic [47:0]      cfg_dst_mac_i,
   input  logic [47:0]      cfg_src_mac_i,
   output logic [DW-1:0]    tx_tdata_o,
   output logic [DW/8-1:0]  tx_tkeep_o,
   output logic             tx_tlast_o,
   output logic             tx_tvalid_o,
   input  logic             tx_tready_i,
   input  logic [DW-1:0]    rx_tdata_i,
   input  logic [DW/8-1:0]  rx_tkeep_i,
   input  logic             rx_tlast_i,
   input  logic             rx_tvalid_i,
   output logic             rx_tready_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [CNT_W-1:0] frames_ok_o,
   output logic [CNT_W-1:0] frames_err_o
);
   localparam int NB = DW / 8;
   localparam int GW = $clog2(IFG_CYCLES + 1);
   gen_state_e g_st, g_nxt;
   chk_state_e c_st, c_nxt;
   logic [CNT_W-1:0] n_frames, g_frame, c_frame;
   logic [10:0] len, len_clamp, g_beat, c_beat;
   logic [47:0] dst, src;
   logic [GW-1:0] gap;
   logic mode, c_bad;
   logic [DW-1:0] g_data, c_data, kmask;
   logic [NB-1:0] g_keep, c_keep;
   logic g_last, c_last;
   logic start_ok, tx_hs, gap_end, g_end, rx_hs, mism, frame_done, frame_good, go_drain, fin;

   eth_tg_pattern #(.DW(DW)) u_gen (
      .frame(g_frame[7:0]), .beat(g_beat), .len(len), .mode(mode), .dst(dst), .src(src),
      .data(g_data), .keep(g_keep), .last(g_last)
   );
   eth_tg_pattern #(.DW(DW)) u_chk (
      .frame(c_frame[7:0]), .beat(c_beat), .len(len), .mode(mode), .dst(dst), .src(src),
      .data(c_data), .keep(c_keep), .last(c_last)
   );

   for (genvar i = 0; i < NB; i++) begin : g_mask
      assign kmask[8*i +: 8] = {8{c_keep[i]}};
   end

   assign len_clamp = (cfg_len_i < 11'(MIN_LEN)) ? 11'(MIN_LEN) :
                      (cfg_len_i > 11'(MAX_LEN)) ? 11'(MAX_LEN) : cfg_len_i;
   assign start_ok = start_i && !busy_o;
   assign tx_tvalid_o = g_st == G_SEND;
   assign tx_tdata_o = tx_tvalid_o ? g_data : '0;
   assign tx_tkeep_o = tx_tvalid_o ? g_keep : '0;
   assign tx_tlast_o = tx_tvalid_o && g_last;
   assign tx_hs = tx_tvalid_o && tx_tready_i;
   assign gap_end = g_st == G_GAP && gap == GW'(IFG_CYCLES - 1);
   assign g_end = g_frame + CNT_W'(1) == n_frames;
   assign rx_hs = rx_tvalid_i && rx_tready_o && c_st != C_IDLE;
   assign mism = rx_tkeep_i != c_keep || ((rx_tdata_i ^ c_data) & kmask) != '0 || rx_tlast_i != c_last;
   assign frame_done = rx_hs && rx_tlast_i;
   assign frame_good = c_st == C_RECV && !c_bad && !mism;
   // expected last beat arrived without tlast: discard until the stream resynchronises
   assign go_drain = rx_hs && c_st == C_RECV && c_last && !rx_tlast_i;
   assign fin = g_st == G_FIN && ({1'b0, frames_ok_o} + {1'b0, frames_err_o}) == {1'b0, n_frames};

   always_comb begin
      g_nxt = g_st;
      c_nxt = c_st;
      if (fin) begin
         g_nxt = G_IDLE;
         c_nxt = C_IDLE;
      end else if (start_ok) begin
         g_nxt = (cfg_frames_i != '0) ? G_SEND : G_FIN;
         c_nxt = C_RECV;
      end else begin
         if (tx_hs && g_last) g_nxt = G_GAP;
         if (gap_end) g_nxt = g_end ? G_FIN : G_SEND;
         if (go_drain) c_nxt = C_DRAIN;
         if (frame_done) c_nxt = C_RECV;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         g_st <= G_IDLE;
         c_st <= C_IDLE;
         n_frames <= '0;
         len <= '0;
         mode <= MODE_INC;
         dst <= '0;
         src <= '0;
         g_frame <= '0;
         g_beat <= '0;
         gap <= '0;
         c_frame <= '0;
         c_beat <= '0;
         c_bad <= 1'b0;
         frames_ok_o <= '0;
         frames_err_o <= '0;
         busy_o <= 1'b0;
         done_o <= 1'b0;
         rx_tready_o <= 1'b0;
      end else begin
         g_st <= g_nxt;
         c_st <= c_nxt;
         rx_tready_o <= 1'b1;
         if (start_ok) begin
            n_frames <= cfg_frames_i;
            len <= len_clamp;
            mode <= cfg_mode_i;
            dst <= cfg_dst_mac_i;
            src <= cfg_src_mac_i;
            g_frame <= '0;
            g_beat <= '0;
            gap <= '0;
            c_frame <= '0;
            c_beat <= '0;
            c_bad <= 1'b0;
            frames_ok_o <= '0;
            frames_err_o <= '0;
            busy_o <= 1'b1;
            done_o <= 1'b0;
         end
         if (fin) begin
            busy_o <= 1'b0;
            done_o <= 1'b1;
         end
         if (tx_hs) g_beat <= g_last ? '0 : g_beat + 11'd1;
         if (g_st == G_GAP) gap <= gap_end ? '0 : gap + GW'(1);
         if (gap_end) g_frame <= g_frame + CNT_W'(1);
         if (rx_hs) begin
            c_bad <= !frame_done && (c_bad || mism);
            c_beat <= frame_done ? '0 : c_beat + 11'd1;
            if (frame_done) c_frame <= c_frame + CNT_W'(1);
         end
         if (frame_done && frame_good && frames_ok_o != '1) frames_ok_o <= frames_ok_o + CNT_W'(1);
         if (frame_done && !frame_good && frames_err_o != '1) frames_err_o <= frames_err_o + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_eth_traffic_gen_chk.sv
// tb_eth_traffic_gen_chk: loopback bench with a tx beat scoreboard, rx fault injection and counter checks.
module tb_eth_traffic_gen_chk;
   localparam int NB = 8;
   typedef struct packed {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
   } beat_t;

   logic clk = 1'b0;
   logic rst_ni = 1'b0;
   logic start_i = 1'b0;
   logic [15:0] cfg_frames_i = '0;
   logic [10:0] cfg_len_i = '0;
   logic cfg_mode_i = 1'b0;
   logic [47:0] cfg_dst_mac_i = 48'h02_11_22_33_44_55;
   logic [47:0] cfg_src_mac_i = 48'hA6_B7_C8_D9_EA_FB;
   logic [63:0] tx_tdata_o, rx_tdata_i = '0;
   logic [7:0] tx_tkeep_o, rx_tkeep_i = '0;
   logic tx_tlast_o, tx_tvalid_o, tx_tready_i = 1'b0;
   logic rx_tlast_i = 1'b0, rx_tvalid_i = 1'b0, rx_tready_o;
   logic busy_o, done_o;
   logic [15:0] frames_ok_o, frames_err_o;

   beat_t exp_q[$], lb_q[$];
   beat_t e, r;
   logic [63:0] m, d, held_d;
   logic bp = 1'b0, stalled = 1'b0;
   int fault = 0, tfr = 0, tbt = 0;
   int n_chk = 0, n_fail = 0;

   eth_traffic_gen_chk #(.DW(64), .MAX_LEN(1500), .CNT_W(16), .IFG_CYCLES(12)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .cfg_frames_i(cfg_frames_i),
      .cfg_len_i(cfg_len_i), .cfg_mode_i(cfg_mode_i), .cfg_dst_mac_i(cfg_dst_mac_i),
      .cfg_src_mac_i(cfg_src_mac_i), .tx_tdata_o(tx_tdata_o), .tx_tkeep_o(tx_tkeep_o),
      .tx_tlast_o(tx_tlast_o), .tx_tvalid_o(tx_tvalid_o), .tx_tready_i(tx_tready_i),
      .rx_tdata_i(rx_tdata_i), .rx_tkeep_i(rx_tkeep_i), .rx_tlast_i(rx_tlast_i),
      .rx_tvalid_i(rx_tvalid_i), .rx_tready_o(rx_tready_o), .busy_o(busy_o), .done_o(done_o),
      .frames_ok_o(frames_ok_o), .frames_err_o(frames_err_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] fbyte(int f, int b, int len, bit md, logic [47:0] dm, logic [47:0] sm);
      if (b < 6) return dm[47 - 8*b -: 8];
      if (b < 12) return sm[47 - 8*(b - 6) -: 8];
      if (b == 12) return 8'(len >> 8);
      if (b == 13) return 8'(len);
      return md ? ~8'(b - 14) : 8'(b - 14 + f);
   endfunction

   task automatic run_start(int frames, int len, bit md, bit backp, int flt);
      int el, t, nbt, b;
      beat_t x;
      @(negedge clk);
      cfg_frames_i = 16'(frames);
      cfg_len_i = 11'(len);
      cfg_mode_i = md;
      bp = backp;
      fault = flt;
      start_i = 1'b1;
      el = len < 46 ? 46 : (len > 1500 ? 1500 : len);
      t = 14 + el;
      nbt = (t + NB - 1) / NB;
      for (int f = 0; f < frames; f++)
         for (int bt = 0; bt < nbt; bt++) begin
            x = '0;
            for (int i = 0; i < NB; i++) begin
               b = bt * NB + i;
               x.k[i] = b < t;
               if (b < t) x.d[8*i +: 8] = fbyte(f, b, el, md, cfg_dst_mac_i, cfg_src_mac_i);
            end
            x.l = bt == nbt - 1;
            exp_q.push_back(x);
         end
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic wait_done(int max);
      int n = 0;
      while (!done_o && n < max) begin
         @(negedge clk);
         n++;
      end
      check("done_reached", done_o, 1);
   endtask

   task automatic end_run(string tag, int ok, int err);
      wait_done(5000);
      check({tag, "_ok"}, frames_ok_o, 64'(ok));
      check({tag, "_err"}, frames_err_o, 64'(err));
      check({tag, "_busy"}, busy_o, 0);
      check({tag, "_tx_left"}, exp_q.size(), 0);
   endtask

   // tx monitor, scoreboard pop and loopback with optional fault injection
   always @(negedge clk) begin
      if (!rst_ni) begin
         tx_tready_i = 1'b0;
         rx_tvalid_i = 1'b0;
         rx_tlast_i = 1'b0;
         lb_q.delete();
         stalled = 1'b0;
         tfr = 0;
         tbt = 0;
      end else begin
         if (!busy_o) begin
            tfr = 0;
            tbt = 0;
         end
         if (stalled) check("tx_stable", tx_tdata_o, held_d);
         tx_tready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         stalled = tx_tvalid_o && !tx_tready_i;
         held_d = tx_tdata_o;
         if (tx_tvalid_o && tx_tready_i) begin
            if (exp_q.size() == 0) check("tx_extra_beat", 1, 0);
            else begin
               e = exp_q.pop_front();
               for (int i = 0; i < NB; i++) m[8*i +: 8] = {8{e.k[i]}};
               check("tx_keep", tx_tkeep_o, e.k);
               check("tx_last", tx_tlast_o, e.l);
               check("tx_data", tx_tdata_o & m, e.d & m);
            end
            d = tx_tdata_o;
            if (fault == 1 && tfr == 2 && tbt == 17 / NB) d[8*(17 % NB)] = ~d[8*(17 % NB)];
            if (!(fault == 2 && tfr == 0 && tbt > 5)) begin
               r.d = d;
               r.k = tx_tkeep_o;
               r.l = (fault == 2 && tfr == 0 && tbt == 5) || (tx_tlast_o && !(fault == 2 && tfr == 1));
               lb_q.push_back(r);
            end
            if (fault == 2 && tfr == 1 && tx_tlast_o) begin
               r.d = '0;
               r.k = '1;
               r.l = 1'b1;
               lb_q.push_back(r);
            end
            if (tx_tlast_o) begin
               tfr++;
               tbt = 0;
            end else tbt++;
         end
         if (lb_q.size() != 0 && rx_tready_o) begin
            r = lb_q.pop_front();
            rx_tdata_i = r.d;
            rx_tkeep_i = r.k;
            rx_tlast_i = r.l;
            rx_tvalid_i = 1'b1;
         end else rx_tvalid_i = 1'b0;
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_tvalid", tx_tvalid_o, 0);
      check("rst_tdata", tx_tdata_o, 0);
      check("rst_tkeep_tlast", {tx_tkeep_o, tx_tlast_o}, 0);
      check("rst_rx_tready", rx_tready_o, 0);
      check("rst_busy_done", {busy_o, done_o}, 0);
      check("rst_counters", {frames_ok_o, frames_err_o}, 0);
      rst_ni = 1'b1;
      @(negedge clk);
      check("rx_tready_idle", rx_tready_o, 1);

      run_start(8, 46, 0, 0, 0);
      check("busy_set", busy_o, 1);
      repeat (10) @(negedge clk);
      cfg_frames_i = 16'd3;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      end_run("inc46", 8, 0);
      repeat (3) @(negedge clk);
      check("done_held", done_o, 1);

      run_start(4, 47, 1, 1, 0);
      end_run("inv47_bp", 4, 0);

      run_start(5, 100, 0, 0, 1);
      end_run("bitflip", 4, 1);

      run_start(5, 46, 0, 0, 2);
      end_run("early_missing", 3, 2);

      run_start(2, 2000, 1, 0, 0);
      end_run("len_clamp_max", 2, 0);

      @(negedge clk);
      cfg_frames_i = '0;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      check("zero_busy", busy_o, 1);
      check("zero_done_early", done_o, 0);
      check("zero_tvalid_a", tx_tvalid_o, 0);
      @(negedge clk);
      check("zero_done", done_o, 1);
      check("zero_busy_clr", busy_o, 0);
      check("zero_tvalid_b", tx_tvalid_o, 0);
      check("zero_counts", {frames_ok_o, frames_err_o}, 0);

      run_start(4, 46, 0, 0, 0);
      repeat (20) @(negedge clk);
      #2 rst_ni = 1'b0;
      #1;
      check("arst_tvalid", tx_tvalid_o, 0);
      check("arst_tdata", tx_tdata_o, 0);
      check("arst_busy_done", {busy_o, done_o}, 0);
      check("arst_counts", {frames_ok_o, frames_err_o}, 0);
      check("arst_rx_tready", rx_tready_o, 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_ni = 1'b1;
      @(negedge clk);
      run_start(3, 60, 1, 0, 0);
      end_run("after_reset", 3, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
